// File: rtl/mem_arbiter_nport.sv
// N-requester arbiter in front of the single physical memory port.
// Fixed-priority or round-robin grant, latched op type, one-cycle recovery gap between transactions.
module mem_arbiter_nport #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 256,
    parameter int RR_MODE    = 0,
    localparam int GW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_read,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_resp,
    output logic [DATA_WIDTH-1:0]         req_rdata,
    output logic                          mem_read,
    output logic                          mem_write,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    input  logic                          mem_resp,
    input  logic [DATA_WIDTH-1:0]         mem_rdata,
    output logic                          grant_valid,
    output logic [GW-1:0]                 grant_id
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RECOVER
    } state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] grant_id_q, grant_id_d;
    logic [GW-1:0] rr_ptr_q, rr_ptr_d;
    logic          mem_read_q, mem_read_d;
    logic          mem_write_q, mem_write_d;
    logic          grant_valid_q, grant_valid_d;

    logic [NUM_REQ-1:0]    active;
    logic                  any_active;
    logic [GW-1:0]         winner;
    logic [GW-1:0]         next_ptr;
    int                    rr_idx;
    logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

    assign active     = req_read | req_write;
    assign any_active = |active;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign wdata_arr[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
            assign req_resp[gi]  = grant_valid_q && mem_resp && (grant_id_q == GW'(gi));
        end
    endgenerate

    // Searching from the far end lets the last hit (closest to the start point) win.
    always_comb begin
        winner = '0;
        rr_idx = 0;
        if (RR_MODE == 0) begin
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                if (active[i]) winner = GW'(i);
            end
        end else begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                rr_idx = (int'(rr_ptr_q) + k) % NUM_REQ;
                if (active[rr_idx]) winner = GW'(rr_idx);
            end
        end
    end

    assign next_ptr = (grant_id_q == GW'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        grant_id_d    = grant_id_q;
        rr_ptr_d      = rr_ptr_q;
        mem_read_d    = mem_read_q;
        mem_write_d   = mem_write_q;
        grant_valid_d = grant_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (any_active) begin
                    state_d       = ST_BUSY;
                    grant_id_d    = winner;
                    mem_write_d   = req_write[winner];
                    mem_read_d    = !req_write[winner];
                    grant_valid_d = 1'b1;
                end
            end
            ST_BUSY: begin
                // The op stays latched even if the requester drops its request early.
                if (mem_resp) begin
                    state_d       = ST_RECOVER;
                    rr_ptr_d      = next_ptr;
                    mem_read_d    = 1'b0;
                    mem_write_d   = 1'b0;
                    grant_valid_d = 1'b0;
                end
            end
            ST_RECOVER: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            grant_id_q    <= '0;
            rr_ptr_q      <= '0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            grant_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_id_q    <= grant_id_d;
            rr_ptr_q      <= rr_ptr_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            grant_valid_q <= grant_valid_d;
        end
    end

    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign grant_valid = grant_valid_q;
    assign grant_id    = grant_id_q;
    assign mem_addr    = grant_valid_q ? addr_arr[grant_id_q]  : '0;
    assign mem_wdata   = grant_valid_q ? wdata_arr[grant_id_q] : '0;
    assign req_rdata   = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter_nport.sv
// Bench for mem_arbiter_nport: a 2-port fixed-priority instance and a 4-port round-robin instance,
// each checked every cycle against a transaction-level model, plus literal spot checks.
module tb_mem_arbiter_nport;

    localparam int AW = 32;
    localparam int DW = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0][3:0]      rd, wr;
    logic [1:0][4*AW-1:0] addr;
    logic [1:0][4*DW-1:0] wdata;
    logic [1:0]           mresp;
    logic [1:0][DW-1:0]   mrdata;

    logic [1:0]    fp_resp;
    logic [DW-1:0] fp_rdata, fp_mwdata;
    logic          fp_mrd, fp_mwr, fp_gv;
    logic [AW-1:0] fp_maddr;
    logic [0:0]    fp_gid;

    logic [3:0]    rr_resp;
    logic [DW-1:0] rr_rdata, rr_mwdata;
    logic          rr_mrd, rr_mwr, rr_gv;
    logic [AW-1:0] rr_maddr;
    logic [1:0]    rr_gid;

    mem_arbiter_nport #(.NUM_REQ(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RR_MODE(0)) dut_fp (
        .clk(clk), .rst(rst),
        .req_read(rd[0][1:0]), .req_write(wr[0][1:0]),
        .req_addr(addr[0][2*AW-1:0]), .req_wdata(wdata[0][2*DW-1:0]),
        .req_resp(fp_resp), .req_rdata(fp_rdata),
        .mem_read(fp_mrd), .mem_write(fp_mwr), .mem_addr(fp_maddr), .mem_wdata(fp_mwdata),
        .mem_resp(mresp[0]), .mem_rdata(mrdata[0]),
        .grant_valid(fp_gv), .grant_id(fp_gid)
    );

    mem_arbiter_nport #(.NUM_REQ(4), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RR_MODE(1)) dut_rr (
        .clk(clk), .rst(rst),
        .req_read(rd[1]), .req_write(wr[1]),
        .req_addr(addr[1]), .req_wdata(wdata[1]),
        .req_resp(rr_resp), .req_rdata(rr_rdata),
        .mem_read(rr_mrd), .mem_write(rr_mwr), .mem_addr(rr_maddr), .mem_wdata(rr_mwdata),
        .mem_resp(mresp[1]), .mem_rdata(mrdata[1]),
        .grant_valid(rr_gv), .grant_id(rr_gid)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Transaction-level model: who owns the port, whether the gap cycle is pending, and the fairness pointer.
    int n_of[2] = '{2, 4};
    int rrm[2]  = '{0, 1};
    int owner[2]    = '{-1, -1};
    int last_gid[2] = '{0, 0};
    int ptr[2]      = '{0, 0};
    bit gap[2]      = '{0, 0};
    bit opw[2]      = '{0, 0};

    function automatic int pick(input int d);
        for (int k = 0; k < n_of[d]; k++) begin
            int i;
            i = (rrm[d] != 0) ? (ptr[d] + k) % n_of[d] : k;
            if (rd[d][i] || wr[d][i]) return i;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                owner[d] = -1; gap[d] = 0; ptr[d] = 0; last_gid[d] = 0; opw[d] = 0;
            end else if (owner[d] >= 0) begin
                if (mresp[d]) begin
                    ptr[d]   = (owner[d] + 1) % n_of[d];
                    owner[d] = -1;
                    gap[d]   = 1;
                end
            end else if (gap[d]) begin
                gap[d] = 0;
            end else begin
                int w;
                w = pick(d);
                if (w >= 0) begin
                    owner[d] = w; last_gid[d] = w; opw[d] = wr[d][w];
                end
            end
        end
    end

    task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d got %0h expected %0h", name, d, act, exp);
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            bit busy;
            logic [63:0] e_addr, e_wd, e_resp;
            logic [63:0] a_mrd, a_mwr, a_addr, a_wd, a_resp, a_rdata, a_gv, a_gid;
            busy = owner[d] >= 0;
            e_addr = '0; e_wd = '0; e_resp = '0;
            if (busy) begin
                e_addr = 64'(addr[d][owner[d]*AW +: AW]);
                e_wd   = wdata[d][owner[d]*DW +: DW];
                e_resp = mresp[d] ? (64'd1 << owner[d]) : 64'd0;
            end
            if (d == 0) begin
                a_mrd = 64'(fp_mrd); a_mwr = 64'(fp_mwr); a_addr = 64'(fp_maddr); a_wd = fp_mwdata;
                a_resp = 64'(fp_resp); a_rdata = fp_rdata; a_gv = 64'(fp_gv); a_gid = 64'(fp_gid);
            end else begin
                a_mrd = 64'(rr_mrd); a_mwr = 64'(rr_mwr); a_addr = 64'(rr_maddr); a_wd = rr_mwdata;
                a_resp = 64'(rr_resp); a_rdata = rr_rdata; a_gv = 64'(rr_gv); a_gid = 64'(rr_gid);
            end
            chk("mem_read",    d, a_mrd,   64'(busy && !opw[d]));
            chk("mem_write",   d, a_mwr,   64'(busy && opw[d]));
            chk("grant_valid", d, a_gv,    64'(busy));
            chk("grant_id",    d, a_gid,   64'(last_gid[d]));
            chk("mem_addr",    d, a_addr,  e_addr);
            chk("mem_wdata",   d, a_wd,    e_wd);
            chk("req_resp",    d, a_resp,  e_resp);
            chk("req_rdata",   d, a_rdata, mrdata[d]);
        end
    endtask

    always @(negedge clk) begin
        #4;
        check_all();
    end

    // Grant order log: one entry each time grant_valid rises.
    int  glog0[$];
    int  glog1[$];
    bit  pgv0 = 0, pgv1 = 0;
    always @(negedge clk) begin
        if (fp_gv && !pgv0) glog0.push_back(int'(fp_gid));
        if (rr_gv && !pgv1) glog1.push_back(int'(rr_gid));
        pgv0 = fp_gv;
        pgv1 = rr_gv;
    end

    function automatic bit gv_of(input int d);
        return (d == 0) ? fp_gv : rr_gv;
    endfunction

    function automatic int gid_of(input int d);
        return (d == 0) ? int'(fp_gid) : int'(rr_gid);
    endfunction

    // Wait (bounded) for a grant, answer after 'delay' cycles, optionally retire the requester in RECOVER.
    task automatic serve(input int d, input int delay, input bit drop);
        int k;
        int g;
        k = 0;
        while (!gv_of(d) && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!gv_of(d)) begin
            n_tests++;
            n_fail++;
            $display("FAIL serve_timeout dut%0d got no grant expected grant within 20 cycles", d);
            return;
        end
        g = gid_of(d);
        repeat (delay) @(negedge clk);
        mresp[d]  = 1'b1;
        mrdata[d] = 64'hA5A5_0000_0000_0000 | 64'(g);
        @(negedge clk);
        mresp[d] = 1'b0;
        if (drop) begin
            rd[d][g] = 1'b0;
            wr[d][g] = 1'b0;
        end
        $display("[TB] txn dut%0d grant %0d", d, g);
    endtask

    task automatic chk_log(input string name, input int d, input int got[$], input int exp[$]);
        chk({name, "_len"}, d, 64'(got.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            chk(name, d, 64'(got[i]), 64'(exp[i]));
    endtask

    initial begin
        rd = '0; wr = '0; addr = '0; wdata = '0; mresp = '0; mrdata = '0;
        repeat (3) @(negedge clk);
        chk("reset_gv", 0, 64'(fp_gv), 64'd0);
        chk("reset_mrd", 1, 64'(rr_mrd), 64'd0);
        chk("reset_gid", 1, 64'(rr_gid), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single read from requester 1
        rd[0] = 4'b0010;
        addr[0][1*AW +: AW] = 32'h100;
        @(negedge clk); #1;
        chk("t1_mem_read", 0, 64'(fp_mrd), 64'd1);
        chk("t1_mem_addr", 0, 64'(fp_maddr), 64'h100);
        chk("t1_grant_id", 0, 64'(fp_gid), 64'd1);
        @(negedge clk);
        @(negedge clk);
        mresp[0] = 1'b1;
        mrdata[0] = 64'h1111_2222_3333_4444;
        #1;
        chk("t1_resp", 0, 64'(fp_resp), 64'b10);
        chk("t1_rdata", 0, fp_rdata, 64'h1111_2222_3333_4444);
        @(negedge clk);
        mresp[0] = 1'b0;
        rd[0] = '0;
        #1;
        chk("t1_recover_read", 0, 64'(fp_mrd), 64'd0);
        chk("t1_recover_gv", 0, 64'(fp_gv), 64'd0);
        $display("[TB] txn dut0 single read done");
        repeat (2) @(negedge clk);

        // Fixed priority: write from 0 beats read from 1
        glog0.delete();
        wr[0] = 4'b0001;
        rd[0] = 4'b0010;
        addr[0][0 +: AW]  = 32'h200;
        addr[0][AW +: AW] = 32'h300;
        wdata[0][0 +: DW] = 64'hCAFE_F00D_0000_0001;
        @(negedge clk); #1;
        chk("t2_first_write", 0, 64'(fp_mwr), 64'd1);
        chk("t2_first_addr", 0, 64'(fp_maddr), 64'h200);
        serve(0, 1, 1);
        serve(0, 1, 1);
        chk_log("t2_grant_seq", 0, glog0, '{0, 1});
        repeat (2) @(negedge clk);

        // Read+write on the same requester is a write
        rd[0] = 4'b0001;
        wr[0] = 4'b0001;
        wdata[0][0 +: DW] = 64'h0123_4567_89AB_CDEF;
        @(negedge clk); #1;
        chk("t4_mem_write", 0, 64'(fp_mwr), 64'd1);
        chk("t4_mem_read", 0, 64'(fp_mrd), 64'd0);
        chk("t4_mem_wdata", 0, fp_mwdata, 64'h0123_4567_89AB_CDEF);
        serve(0, 0, 1);
        repeat (2) @(negedge clk);

        // Spurious response while idle
        mresp[0] = 1'b1;
        @(negedge clk); #1;
        chk("t6_resp", 0, 64'(fp_resp), 64'd0);
        chk("t6_gv", 0, 64'(fp_gv), 64'd0);
        @(negedge clk); #1;
        chk("t6_resp2", 0, 64'(fp_resp), 64'd0);
        chk("t6_gv2", 0, 64'(fp_gv), 64'd0);
        // mem_resp held high with both requesters active
        rd[0] = 4'b0011;
        repeat (8) @(negedge clk);
        rd[0] = '0;
        mresp[0] = 1'b0;
        repeat (3) @(negedge clk);

        // Round-robin fairness, all four requesting continuously
        glog1.delete();
        for (int i = 0; i < 4; i++) begin
            addr[1][i*AW +: AW]  = 32'h1000 + 32'(i * 16);
            wdata[1][i*DW +: DW] = 64'hBEEF_0000 + 64'(i);
        end
        rd[1] = 4'b1111;
        for (int t = 0; t < 5; t++) serve(1, 1, 0);
        rd[1] = '0;
        chk_log("t3_grant_seq", 1, glog1, '{0, 1, 2, 3, 0});
        repeat (2) @(negedge clk);

        // Asynchronous reset mid-BUSY; pointer must return to 0
        rd[1] = 4'b1001;
        @(negedge clk); #1;
        chk("t5_pre_gid", 1, 64'(rr_gid), 64'd3);
        rst = 1'b1;
        #1;
        chk("t5_rst_mrd", 1, 64'(rr_mrd), 64'd0);
        chk("t5_rst_gv", 1, 64'(rr_gv), 64'd0);
        chk("t5_rst_gid", 1, 64'(rr_gid), 64'd0);
        rst = 1'b0;
        @(negedge clk); #1;
        chk("t5_regrant_gid", 1, 64'(rr_gid), 64'd0);
        chk("t5_regrant_gv", 1, 64'(rr_gv), 64'd1);
        serve(1, 1, 1);
        serve(1, 1, 1);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
